coin_move_ctrl: RTL and testbench
=================================

# coin_move_ctrl

Sequencer for a single falling coin sprite on the 160x120 VGA framebuffer. Each frame tick from the frame counter starts a fixed sequence: erase the coin at its old position, update its position, then redraw it. Pixels are emitted one per clock to the VGA adapter's plot port. The block also handles respawn when the coin is caught by the player or falls off the bottom of the screen.

## Interface
- COIN_SIZE, 4 — sprite edge in pixels; legal values 2, 4, 8
- SCREEN_W, 160 — screen width; must be ≥ 144
- SCREEN_H, 120 — screen height
- START_X, 80 — reset and non-random respawn x
- STEP, 1 — y increment per frame; 1..COIN_SIZE
- COIN_COLOUR, 3'b110 — draw colour
- BG_COLOUR, 3'b000 — erase colour

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-low
- frame_tick  in  1  one-cycle pulse from the frame counter
- enable  in  1  level; game running
- caught  in  1  one-cycle pulse; player caught the coin
- x_out  out  8  pixel x to VGA adapter
- y_out  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high while not in IDLE or WAIT_FRAME
- coin_x  out  8  current coin top-left x
- coin_y  out  7  current coin top-left y
- missed  out  1  one-cycle pulse; coin left the bottom of the screen

## Operation
- States: IDLE, WAIT_FRAME, ERASE, UPDATE, DRAW.
- IDLE: if enable=1, go to DRAW to perform the initial draw at (coin_x, coin_y).
- WAIT_FRAME:
  - If enable=0, go to IDLE.
  - Else if frame_tick=1, go to ERASE.
- ERASE: a pixel counter pix (log2(COIN_SIZE²) bits) walks in raster order, with dx = low half of pix and dy = high half. Each cycle outputs x_out = coin_x+dx, y_out = coin_y+dy, colour = BG_COLOUR, plot = 1. After the last pixel, pix wraps to 0 and the state goes to UPDATE.
- UPDATE: one cycle, plot = 0. Position update, in priority order:
  1. caught_pend=1: set coin_y = 0, set coin_x = respawn x, clear caught_pend. missed is not asserted.
  2. coin_y + STEP > SCREEN_H − COIN_SIZE: assert missed for this cycle, set coin_y = 0, set coin_x = respawn x.
  3. Otherwise: coin_y = coin_y + STEP.
  - Then go to DRAW.
- DRAW: same pixel walk as ERASE, with colour = COIN_COLOUR. After the last pixel, go to WAIT_FRAME.
- caught_pend is set by a caught pulse in any state except IDLE. It is cleared only in UPDATE or by reset. A caught pulse arriving in the UPDATE cycle itself is held over to the next UPDATE.
- A frame_tick seen in any state other than WAIT_FRAME is dropped, not queued.
- enable falling mid-sequence: the current ERASE/UPDATE/DRAW sequence completes. The block then passes through WAIT_FRAME to IDLE, and the coin stays drawn.
- Arithmetic is unsigned. coin_y + STEP is computed at 8 bits so it cannot wrap.

## Timing
- Reset values: state IDLE, coin_x = START_X, coin_y = 0, pix = 0, caught_pend = 0. All outputs not listed here are 0.
- x_out, y_out, colour and plot are combinational from state, pix and position registers. missed and busy are also combinational from state.
- frame_tick high at edge t → ERASE from cycle t+1. First pixel is plotted at t+1.
- Sequence length is 2·COIN_SIZE² + 1 cycles: 33 cycles at the defaults. busy is high for exactly those cycles.
- An asserted resetn clears state immediately, including mid-ERASE or mid-DRAW. A partially drawn sprite is left on screen and is not cleaned up.

## Configuration
- COIN_RANDOM_X_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset) steps every clock. Respawn x = {1'b0, lfsr[6:0]} + 8, giving a range of 8..135.
- COIN_RANDOM_X_EN undefined: no LFSR is built, and respawn x = START_X.

## Test plan
- Reset, then enable=1 → 16 DRAW plots at x 80..83, y 0..3, colour 6. Then WAIT_FRAME, with busy low.
- frame_tick pulse → 16 plots with colour 0 at y 0..3, one cycle with plot=0, then 16 plots with colour 6 at y 1..4. coin_y = 1 and busy is high for 33 cycles.
- Set coin_y to 116 via ticks, then one more tick → missed pulses once in UPDATE, and the coin is redrawn at y 0..3.
- caught pulse during DRAW with coin_y = 116, then a tick → coin_y = 0 and missed stays 0 (caught wins over the bottom edge).
- frame_tick during ERASE → ignored: exactly one update occurs. Also assert resetn low mid-DRAW → all outputs 0 and coin_x = 80 at the next edge.
- With COIN_RANDOM_X_EN defined → respawned coin_x is always in 8..135. Two respawns far enough apart give different x values.

Source files
------------

// File: rtl/coin_move_ctrl.sv
// coin_move_ctrl: erase/update/redraw sequencer for one falling coin sprite; define COIN_RANDOM_X_EN for LFSR respawn x
module coin_move_ctrl #(
  parameter int COIN_SIZE = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int START_X = 80,
  parameter int STEP = 1,
  parameter logic [2:0] COIN_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       caught,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [7:0] coin_x,
  output logic [6:0] coin_y,
  output logic       missed
);
  localparam int LW = $clog2(COIN_SIZE);
  localparam int PW = 2 * LW;
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - COIN_SIZE);
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, ERASE, UPDATE, DRAW} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pix, pix_nx;
  logic [7:0] cx, cx_nx, y_step, raw_x, respawn_x;
  logic [6:0] cy, cy_nx;
  logic pend, pend_nx, walk, last, bottom;
`ifdef COIN_RANDOM_X_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign raw_x = {1'b0, lfsr[6:0]} + 8'd8;
`else
  assign raw_x = 8'(START_X);
`endif
  // keeps the sprite fully on screen for any legal width
  assign respawn_x = raw_x > X_MAX ? X_MAX : raw_x;
  assign y_step = {1'b0, cy} + 8'(STEP);
  assign bottom = y_step > 8'(SCREEN_H - COIN_SIZE);
  assign last = &pix;
  assign walk = state == ERASE || state == DRAW;
  assign x_out = walk ? cx + 8'(pix[LW-1:0]) : '0;
  assign y_out = walk ? cy + 7'(pix[PW-1:LW]) : '0;
  assign colour = state == ERASE ? BG_COLOUR : state == DRAW ? COIN_COLOUR : 3'b000;
  assign plot = walk;
  assign busy = walk || state == UPDATE;
  assign missed = state == UPDATE && !pend && bottom;
  assign coin_x = cx;
  assign coin_y = cy;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pix <= '0;
      cx <= 8'(START_X);
      cy <= '0;
      pend <= 1'b0;
    end else begin
      state <= state_nx;
      pix <= pix_nx;
      cx <= cx_nx;
      cy <= cy_nx;
      pend <= pend_nx;
    end
  always_comb begin
    state_nx = state;
    pix_nx = pix;
    cx_nx = cx;
    cy_nx = cy;
    pend_nx = state == IDLE ? pend : pend | caught;
    case (state)
      IDLE: state_nx = enable ? DRAW : IDLE;
      WAIT_FRAME: state_nx = !enable ? IDLE : frame_tick ? ERASE : WAIT_FRAME;
      ERASE: begin
        pix_nx = pix + 1'b1;
        state_nx = last ? UPDATE : ERASE;
      end
      UPDATE: begin
        // a catch landing in this very cycle counts toward the next update
        pend_nx = caught;
        state_nx = DRAW;
        cx_nx = pend || bottom ? respawn_x : cx;
        cy_nx = pend || bottom ? 7'd0 : y_step[6:0];
      end
      DRAW: begin
        pix_nx = pix + 1'b1;
        state_nx = last ? WAIT_FRAME : DRAW;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_coin_move_ctrl.sv
// tb_coin_move_ctrl: randomized frame sequences against a position/pixel-list reference model
module tb_coin_move_ctrl;
  localparam int S = 4;
  localparam int H = 120;
  localparam int SX = 80;
  localparam int STEP = 1;
  logic clk = 0, resetn = 0, frame_tick = 0, enable = 0, caught = 0;
  logic [7:0] x_out, coin_x;
  logic [6:0] y_out, coin_y;
  logic [2:0] colour;
  logic plot, busy, missed;
  int checks = 0, fails = 0;
  int mx = SX, my = 0;
  bit pend = 0;
  coin_move_ctrl dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enable(enable), .caught(caught),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .busy(busy),
    .coin_x(coin_x), .coin_y(coin_y), .missed(missed)
  );
  always #5 clk = ~clk;

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n, input int c_at);
    for (int k = 0; k < n; k++) begin
      caught = (k == c_at);
      if (caught) pend = 1;
      checks++;
      if (plot !== 1'b0 || busy !== 1'b0 || missed !== 1'b0) begin
        fails++;
        $display("FAIL wait%0d: plot=%b busy=%b missed=%b, required 0 0 0", k, plot, busy, missed);
      end
      tick_cycle();
    end
    caught = 0;
  endtask

  task automatic draw_from_idle(input string tag);
    logic [7:0] ex;
    logic [6:0] ey;
    enable = 1;
    tick_cycle();
    for (int k = 0; k < S * S; k++) begin
      ex = 8'(mx + k % S);
      ey = 7'(my + k / S);
      checks++;
      if (plot !== 1'b1 || busy !== 1'b1 || x_out !== ex || y_out !== ey || colour !== 3'b110) begin
        fails++;
        $display("FAIL %s draw%0d: plot=%b busy=%b x=%0d y=%0d col=%0d, required 1 1 x=%0d y=%0d col=6",
                 tag, k, plot, busy, x_out, y_out, colour, ex, ey);
      end
      tick_cycle();
    end
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s after draw: plot=%b busy=%b, required 0 0", tag, plot, busy);
    end
  endtask

  // one full frame from WAIT_FRAME; *_at = cycle index within the 33-cycle sequence, -1 = none
  task automatic run_seq(input string tag, input int c_at, input int t_at, input int e_at);
    int ox, oy;
    bit cp, ep, em;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    ox = mx;
    oy = my;
    em = 0;
    frame_tick = 1;
    tick_cycle();
    for (int i = 0; i < 2 * S * S + 1; i++) begin
      caught = (i == c_at);
      frame_tick = (i == t_at);
      if (i == e_at) enable = 0;
      cp = (i != S * S);
      ep = cp;
      ex = 0;
      ey = 0;
      ec = 0;
      if (i < S * S) begin
        ex = 8'(ox + i % S);
        ey = 7'(oy + i / S);
        ec = 3'b000;
        em = 0;
      end else if (i == S * S) begin
        em = 0;
        if (pend) begin
          mx = SX;
          my = 0;
        end else if (my + STEP > H - S) begin
          em = 1;
          mx = SX;
          my = 0;
        end else my = my + STEP;
`ifdef COIN_RANDOM_X_EN
        if (pend || em) mx = -1;
`endif
        pend = caught;
      end else begin
`ifdef COIN_RANDOM_X_EN
        if (mx < 0) begin
          checks++;
          if (coin_x < 8 || coin_x > 135) begin
            fails++;
            $display("FAIL %s respawn range: coin_x=%0d, required 8..135", tag, coin_x);
          end
          mx = coin_x;
        end
`endif
        ex = 8'(mx + (i - S * S - 1) % S);
        ey = 7'(my + (i - S * S - 1) / S);
        ec = 3'b110;
        em = 0;
      end
      if (i != S * S && caught) pend = 1;
      checks++;
      if (plot !== ep || busy !== 1'b1 || missed !== em ||
          (cp && (x_out !== ex || y_out !== ey || colour !== ec))) begin
        fails++;
        $display("FAIL %s cyc%0d: plot=%b busy=%b missed=%b x=%0d y=%0d col=%0d, required plot=%b busy=1 missed=%b x=%0d y=%0d col=%0d",
                 tag, i, plot, busy, missed, x_out, y_out, colour, ep, em, ex, ey, ec);
      end
      if (i == S * S + 1) begin
        checks++;
        if (coin_x !== 8'(mx) || coin_y !== 7'(my)) begin
          fails++;
          $display("FAIL %s position: coin_x=%0d coin_y=%0d, required %0d %0d", tag, coin_x, coin_y, mx, my);
        end
      end
      tick_cycle();
    end
    caught = 0;
    frame_tick = 0;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || missed !== 1'b0) begin
      fails++;
      $display("FAIL %s end: plot=%b busy=%b missed=%b, required 0 0 0", tag, plot, busy, missed);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (2) tick_cycle();
    checks++;
    if (plot !== 0 || busy !== 0 || missed !== 0 || x_out !== 0 || y_out !== 0 || colour !== 0 ||
        coin_x !== 8'(SX) || coin_y !== 0) begin
      fails++;
      $display("FAIL reset: plot=%b busy=%b missed=%b x=%0d y=%0d col=%0d cx=%0d cy=%0d, required zeros and cx=80",
               plot, busy, missed, x_out, y_out, colour, coin_x, coin_y);
    end
    resetn = 1;
    tick_cycle();
    checks++;
    if (plot !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL idle without enable: plot=%b busy=%b, required 0 0", plot, busy);
    end
    mx = SX;
    my = 0;
    pend = 0;
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 24; n++) begin
      idle_wait($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? 0 : -1);
      run_seq("rand", ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32)) : -1,
              ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 32)) : -1, -1);
    end
  endtask

  task automatic climb_to(input int target);
    run_seq("clear", -1, -1, -1);
    for (int n = 0; n < 200 && my != target; n++)
      run_seq("climb", -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : -1, -1);
    checks++;
    if (coin_y !== 7'(target)) begin
      fails++;
      $display("FAIL climb: coin_y=%0d, required %0d", coin_y, target);
    end
  endtask

  task automatic test_bottom();
    climb_to(H - S);
    run_seq("bottom", -1, -1, -1);
  endtask

  task automatic test_caught_wins();
    climb_to(H - S - STEP);
    run_seq("catch in draw", 25, -1, -1);
    run_seq("caught at bottom", -1, -1, -1);
    run_seq("catch in update", S * S, -1, -1);
    run_seq("held over", -1, -1, -1);
  endtask

  task automatic test_enable_drop();
    run_seq("pre drop", -1, -1, -1);
    run_seq("drop", -1, 3, 5);
    tick_cycle();
    for (int k = 0; k < 10; k++) begin
      frame_tick = (k % 3 == 0);
      caught = (k == 4);
      checks++;
      if (plot !== 0 || busy !== 0 || coin_x !== 8'(mx) || coin_y !== 7'(my)) begin
        fails++;
        $display("FAIL idle hold%0d: plot=%b busy=%b cx=%0d cy=%0d, required 0 0 %0d %0d",
                 k, plot, busy, coin_x, coin_y, mx, my);
      end
      tick_cycle();
    end
    frame_tick = 0;
    caught = 0;
    draw_from_idle("redraw");
    run_seq("after idle", -1, -1, -1);
  endtask

  task automatic test_reset_mid_draw();
    frame_tick = 1;
    tick_cycle();
    frame_tick = 0;
    repeat (20) tick_cycle();
    resetn = 0;
    #1;
    checks++;
    if (plot !== 0 || busy !== 0 || missed !== 0 || x_out !== 0 || y_out !== 0 || colour !== 0 ||
        coin_x !== 8'(SX) || coin_y !== 0) begin
      fails++;
      $display("FAIL async reset: plot=%b busy=%b x=%0d y=%0d col=%0d cx=%0d cy=%0d, required zeros and cx=80",
               plot, busy, x_out, y_out, colour, coin_x, coin_y);
    end
    tick_cycle();
    checks++;
    if (plot !== 0 || busy !== 0 || coin_x !== 8'(SX)) begin
      fails++;
      $display("FAIL reset edge: plot=%b busy=%b cx=%0d, required 0 0 80", plot, busy, coin_x);
    end
    resetn = 1;
    mx = SX;
    my = 0;
    pend = 0;
    draw_from_idle("post reset");
    run_seq("post reset frame", -1, -1, -1);
  endtask

`ifdef COIN_RANDOM_X_EN
  task automatic test_random_x();
    int first;
    bit differ;
    first = -1;
    differ = 0;
    for (int n = 0; n < 8; n++) begin
      run_seq("respawn", 3, -1, -1);
      idle_wait(int'($urandom_range(1, 9)), -1);
      if (first < 0) first = mx;
      else if (mx != first) differ = 1;
    end
    checks++;
    if (!differ) begin
      fails++;
      $display("FAIL respawn variety: all x=%0d, required at least two values", first);
    end
  endtask
`endif

  initial begin
    test_reset();
    draw_from_idle("initial");
    run_seq("first frame", -1, -1, -1);
    test_random_frames();
    test_bottom();
    test_caught_wins();
    test_enable_drop();
    test_reset_mid_draw();
`ifdef COIN_RANDOM_X_EN
    test_random_x();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
